// File: rtl/wb_regfile.sv
// Writeback result select plus the 32-entry architectural register file for the RV32I pipeline.
// Decode read ports see the value being committed this cycle through a write-through bypass.
module wb_regfile #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regwriteW,
    input  logic [1:0]            resultsrcW,
    input  logic [WIDTH-1:0]      aluresultW,
    input  logic [WIDTH-1:0]      readdataW,
    input  logic [WIDTH-1:0]      pcplus4W,
    input  logic [ADDR_WIDTH-1:0] rdW,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [ADDR_WIDTH-1:0] a2,
    output logic [WIDTH-1:0]      rd1,
    output logic [WIDTH-1:0]      rd2,
    output logic [WIDTH-1:0]      resultW,
    output logic [WIDTH-1:0]      a0,
    output logic [31:0]           wbcount
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    localparam logic [1:0] SrcAlu  = 2'b00;
    localparam logic [1:0] SrcLoad = 2'b01;
    localparam logic [1:0] SrcPc4  = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] RegZero = '0;
    localparam logic [ADDR_WIDTH-1:0] RegA0   = ADDR_WIDTH'(10);

    logic [WIDTH-1:0] regs_q [NumRegs];
    logic [31:0]      wbcount_q;
    logic             commit;

    // x0 is never written, so its storage holds the reset value forever.
    assign commit = regwriteW && (rdW != RegZero);

    // Reserved select 2'b11 (and any unknown select) falls back to the ALU result.
    always_comb begin
        case (resultsrcW)
            SrcAlu:  resultW = aluresultW;
            SrcLoad: resultW = readdataW;
            SrcPc4:  resultW = pcplus4W;
            default: resultW = aluresultW;
        endcase
    end

    always_comb begin
        if (a1 == RegZero) begin
            rd1 = '0;
        end else if (regwriteW && (rdW == a1)) begin
            rd1 = resultW;
        end else begin
            rd1 = regs_q[a1];
        end
    end

    always_comb begin
        if (a2 == RegZero) begin
            rd2 = '0;
        end else if (regwriteW && (rdW == a2)) begin
            rd2 = resultW;
        end else begin
            rd2 = regs_q[a2];
        end
    end

    // Reset wins over a same-edge write: the write is dropped and not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q    <= '{default: '0};
            wbcount_q <= '0;
        end else if (commit) begin
            regs_q[rdW] <= resultW;
            wbcount_q   <= wbcount_q + 32'd1;
        end
    end

    // a0 is the stored x10 only; it deliberately ignores the bypass.
    assign a0      = regs_q[RegA0];
    assign wbcount = wbcount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected values go into a scoreboard queue as stimulus is
// driven and are popped and compared against the DUT outputs.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwriteW;
    logic [1:0]  resultsrcW;
    logic [31:0] aluresultW;
    logic [31:0] readdataW;
    logic [31:0] pcplus4W;
    logic [4:0]  rdW;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] resultW;
    logic [31:0] a0;
    logic [31:0] wbcount;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q [$];

    wb_regfile #(
        .WIDTH      (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .regwriteW  (regwriteW),
        .resultsrcW (resultsrcW),
        .aluresultW (aluresultW),
        .readdataW  (readdataW),
        .pcplus4W   (pcplus4W),
        .rdW        (rdW),
        .a1         (a1),
        .a2         (a2),
        .rd1        (rd1),
        .rd2        (rd2),
        .resultW    (resultW),
        .a0         (a0),
        .wbcount    (wbcount)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] exp);
        sb_q.push_back(exp);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        regwriteW  = 1'b0;
        resultsrcW = 2'b00;
        aluresultW = '0;
        readdataW  = '0;
        pcplus4W   = '0;
        rdW        = '0;
        a1         = 5'd5;
        a2         = 5'd0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        #1;
        push(32'h0); check("reset_rd1_x5", rd1);
        push(32'h0); check("reset_rd2_x0", rd2);
        push(32'h0); check("reset_a0", a0);
        push(32'h0); check("reset_wbcount", wbcount);
        push(32'h0); check("reset_resultW", resultW);

        // Reset flush after a real write.
        regwriteW = 1'b1; rdW = 5'd5; aluresultW = 32'hDEAD_BEEF;
        tick();
        regwriteW = 1'b0;
        #1;
        push(32'hDEAD_BEEF); check("x5_written", rd1);
        push(32'd1);         check("wbcount_one", wbcount);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        push(32'h0); check("flush_rd1_x5", rd1);
        push(32'h0); check("flush_wbcount", wbcount);
        push(32'h0); check("flush_a0", a0);

        // Reset and write on the same edge: reset wins.
        rst = 1'b1; regwriteW = 1'b1; rdW = 5'd5; aluresultW = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; regwriteW = 1'b0;
        #1;
        push(32'h0); check("rst_vs_write_x5", rd1);
        push(32'h0); check("rst_vs_write_wbcount", wbcount);

        // Result mux over all four selects into x7.
        rdW = 5'd7; a1 = 5'd7; aluresultW = 32'h11; readdataW = 32'h22; pcplus4W = 32'h33;
        for (int s = 0; s < 4; s++) begin
            resultsrcW = 2'(s);
            regwriteW  = 1'b1;
            push((s == 1) ? 32'h22 : (s == 2) ? 32'h33 : 32'h11);
            #1;
            check("mux_resultW", resultW);
            tick();
            regwriteW = 1'b0;
            push((s == 1) ? 32'h22 : (s == 2) ? 32'h33 : 32'h11);
            #1;
            check("mux_stored_x7", rd1);
        end
        push(32'd4); check("mux_wbcount", wbcount);
        resultsrcW = 2'b00;

        // Writes to x0 are dropped.
        regwriteW = 1'b1; rdW = 5'd0; aluresultW = 32'hFFFF_FFFF; a1 = 5'd0; a2 = 5'd7;
        #1;
        push(32'h0);  check("x0_before", rd1);
        push(32'h11); check("x7_port2", rd2);
        tick();
        regwriteW = 1'b0;
        #1;
        push(32'h0); check("x0_after", rd1);
        push(32'd4); check("x0_wbcount", wbcount);

        // Bypass: both ports see the in-flight value.
        regwriteW = 1'b1; rdW = 5'd3; aluresultW = 32'h5;
        tick();
        aluresultW = 32'hA; a1 = 5'd3; a2 = 5'd3;
        #1;
        push(32'hA); check("bypass_rd1", rd1);
        push(32'hA); check("bypass_rd2", rd2);
        tick();
        regwriteW = 1'b0;
        #1;
        push(32'hA); check("stored_rd1", rd1);
        push(32'hA); check("stored_rd2", rd2);
        regwriteW = 1'b1; aluresultW = 32'h5;
        tick();
        regwriteW = 1'b0; aluresultW = 32'hA;
        #1;
        push(32'h5); check("no_bypass_rd1", rd1);
        push(32'h5); check("no_bypass_rd2", rd2);
        push(32'd7); check("bypass_wbcount", wbcount);

        // a0 follows stored x10 one edge after the write; bypass on rd1 is immediate.
        regwriteW = 1'b1; rdW = 5'd10; aluresultW = 32'h1234; a1 = 5'd10;
        #1;
        push(32'h0);    check("a0_during_write", a0);
        push(32'h1234); check("x10_bypass", rd1);
        tick();
        rdW = 5'd11; aluresultW = 32'h9999;
        #1;
        push(32'h1234); check("a0_after_write", a0);
        tick();
        regwriteW = 1'b0; a2 = 5'd11;
        #1;
        push(32'h1234); check("a0_after_x11", a0);
        push(32'h9999); check("x11_stored", rd2);
        push(32'd9);    check("a0_wbcount", wbcount);

        // Counter wrap via deposit.
        dut.wbcount_q = 32'hFFFF_FFFE;
        regwriteW = 1'b1; rdW = 5'd12; aluresultW = 32'h77;
        tick();
        #1;
        push(32'hFFFF_FFFF); check("wrap_ffffffff", wbcount);
        tick();
        regwriteW = 1'b0;
        #1;
        push(32'h0); check("wrap_zero", wbcount);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
